// File: rtl/tt_sweep_pkg.sv
// Shared definitions for the truth-table sweep controller: state encoding and
// vector-space sizing.
package tt_sweep_pkg;

    localparam int NUM_VEC = 16;
    localparam int VEC_W   = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/tt_settle_timer.sv
// Loadable down-counter with a zero flag; it holds each stimulus vector for
// the settle time before sampling.
module tt_settle_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    // A load always wins over counting; the count parks at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/tt_sweep_ctrl.sv
// Exhaustive 4-input sweep sequencer: drives vectors 0..15, captures f/g into
// truth tables and scores them against latched expected masks.
module tt_sweep_ctrl
    import tt_sweep_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] exp_f,
    input  logic [15:0] exp_g,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    input  logic        f,
    input  logic        g,
    output logic        busy,
    output logic        done,
    output logic [15:0] tt_f,
    output logic [15:0] tt_g,
    output logic [4:0]  err_count,
    output logic [3:0]  first_err_idx,
    output logic        pass
);

    localparam logic [CNT_W-1:0] RELOAD   = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(NUM_VEC - 1);

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic             sample_en;
    logic             timer_load;
    logic             timer_zero;
    logic [VEC_W-1:0] vec;
    logic [15:0]      exp_f_q;
    logic [15:0]      exp_g_q;
    logic             mismatch;

    tt_settle_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .en       (state == SETTLE),
        .load_val (RELOAD),
        .zero     (timer_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Abort is only honoured while busy; a SAMPLE cycle that is aborted
    // suppresses its write.
    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        sample_en  = 1'b0;
        timer_load = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    timer_load = 1'b1;
                    state_nxt  = SETTLE;
                end
            end
            SETTLE: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (timer_zero) begin
                    state_nxt = SAMPLE;
                end
            end
            SAMPLE: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else begin
                    sample_en = 1'b1;
                    if (vec == LAST_VEC) begin
                        state_nxt = DONE;
                    end else begin
                        timer_load = 1'b1;
                        state_nxt  = SETTLE;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign mismatch = (f != exp_f_q[vec]) | (g != exp_g_q[vec]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec           <= '0;
            exp_f_q       <= '0;
            exp_g_q       <= '0;
            tt_f          <= '0;
            tt_g          <= '0;
            err_count     <= '0;
            first_err_idx <= '0;
            pass          <= 1'b0;
        end else begin
            if (accept) begin
                vec           <= '0;
                exp_f_q       <= exp_f;
                exp_g_q       <= exp_g;
                tt_f          <= '0;
                tt_g          <= '0;
                err_count     <= '0;
                first_err_idx <= '0;
                pass          <= 1'b0;
            end
            if (sample_en) begin
                tt_f[vec] <= f;
                tt_g[vec] <= g;
                if (mismatch) begin
                    err_count <= err_count + 5'd1;
                    if (err_count == 5'd0) begin
                        first_err_idx <= vec;
                    end
                end
                if (vec != LAST_VEC) begin
                    vec <= vec + 1'b1;
                end
            end
            if (state == DONE) begin
                pass <= (err_count == 5'd0);
            end
        end
    end

    assign {a, b, c, d} = vec;
    assign busy = (state == SETTLE) || (state == SAMPLE);
    assign done = (state == DONE);

endmodule

// File: doc/tt_sweep_ctrl.md
Name: tt_sweep_ctrl

Overview:
- Sequencer for the team's 4-input, 2-output combinational lab functions (inputs a,b,c,d; outputs f,g).
- Drives all 16 input combinations in binary order (a = MSB, d = LSB) and waits a programmable settle time per vector.
- Captures f/g into 16-bit truth-table registers and compares them against expected masks, giving a start/done handshake and a pass flag.
- Replaces hand-written exhaustive stimulus blocks with a synthesizable, clocked self-checker.

Parameters:
- SETTLE_CYCLES, 2, cycles each vector is held before sampling; legal range 1..15.
- CNT_W, 4, settle counter width; must satisfy 2**CNT_W > SETTLE_CYCLES.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin sweep; sampled in IDLE only.
- abort  input  1  terminate sweep; returns to IDLE.
- exp_f  input  16  expected f truth table; bit i = f for vector i.
- exp_g  input  16  expected g truth table.
- a,b,c,d  output  1 each  stimulus to the function under test.
- f,g  input  1 each  function outputs; combinational from a..d.
- busy  output  1  high in SETTLE/SAMPLE.
- done  output  1  one-cycle pulse at sweep completion.
- tt_f  output  16  captured f table.
- tt_g  output  16  captured g table.
- err_count  output  5  number of vectors with f or g mismatch (0..16).
- first_err_idx  output  4  index of first mismatching vector; 0 if none.
- pass  output  1  high when the last completed sweep had err_count==0.

Behaviour:
- Reset (async, any state):
  - State -> IDLE; vec=0, so {a,b,c,d}=0.
  - busy=0, done=0, pass=0.
  - tt_f, tt_g, err_count and first_err_idx all 0.
  - Expected-mask latches cleared.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - start=1 latches exp_f/exp_g, sets vec=0, clears tt_f/tt_g/err_count/first_err_idx and pass, loads cnt=SETTLE_CYCLES-1, then -> SETTLE.
  - start held high re-arms only after DONE returns to IDLE.
- {a,b,c,d} = vec at all times (registered; changes only on the entry edge to SETTLE).
- SETTLE: cnt decrements each cycle; when cnt==0, -> SAMPLE. The vector is held for exactly SETTLE_CYCLES cycles before SAMPLE.
- SAMPLE (one cycle):
  - tt_f[vec]<=f and tt_g[vec]<=g.
  - Mismatch = (f!=exp_f_q[vec]) | (g!=exp_g_q[vec]).
  - On mismatch, err_count+1; first_err_idx<=vec if this is the first mismatch.
  - If vec==15, -> DONE; else vec+1, reload cnt, -> SETTLE.
- DONE (one cycle):
  - done=1 and pass<=(err_count==0); update is final, including the vec-15 result.
  - Then -> IDLE. vec stays 15 until the next start.
- Per-vector cost is SETTLE_CYCLES+1 cycles. done asserts 16*(SETTLE_CYCLES+1) cycles after the start-accept edge.
- busy=1 in SETTLE and SAMPLE. start while busy is ignored, and the expected masks are not re-latched.
- abort:
  - In SETTLE or SAMPLE, -> IDLE next edge; done not pulsed, pass=0.
  - tt_f/tt_g/err_count keep partial values. A SAMPLE in the same cycle as abort does not write.
  - Ignored in IDLE and DONE.
- Simultaneous start and abort in IDLE: start wins.
- Reset mid-sweep returns all outputs to reset values immediately, with no done pulse.
- exp_f/exp_g may change freely after the start cycle.

Decomposition:
- Package tt_sweep_pkg:
  - State encoding (2-bit localparams IDLE=0, SETTLE=1, SAMPLE=2, DONE=3).
  - NUM_VEC=16, VEC_W=4.
- One natural sub-module, tt_settle_timer: loadable down-counter with a zero flag, instantiated once.
- The function under test is instantiated beside the controller in the bench/top; it is not inside it.

Test Plan:
- Pass sweep, f = parity (a^b^c^d), g = (a&b)|(c&d); exp_f=16'h6996, exp_g=16'hF888, SETTLE_CYCLES=2 -> done pulses 48 cycles after start; tt_f=16'h6996, tt_g=16'hF888, err_count=0, pass=1.
- Same DUT, exp_f=16'h69B6 (bit 5 flipped) -> err_count=1, first_err_idx=5, pass=0, tt_f=16'h6996.
- Both exp masks inverted -> err_count=16, first_err_idx=0, pass=0.
- Stimulus order: monitor {a,b,c,d} -> values 0,1,...,15 in sequence, each held exactly SETTLE_CYCLES+1 cycles; a toggles only at the vector 7->8 boundary.
- start pulsed at vector 6 -> ignored; abort at vector 9 -> IDLE next cycle, no done, busy=0, pass=0, tt_f bits 9..15 still 0.
- rst asserted asynchronously mid-SETTLE at vector 4 -> all outputs 0 immediately (before next edge); a new start then completes a full clean sweep.
